// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory slave for a core's load/store bus.
// Each request is accepted in IDLE and waits WAIT_CYCLES cycles. The access is
// performed on the edge that enters RESP. The response is then held until
// rsp_ready is seen high.
// Optional feature: define DMEM_BYTE_STROBE_EN to honour req_be on stores.
// Without that macro, every legal store writes the full word.
module dmem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        we_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic [3:0]  be_reg;
  logic [31:0] rdata_reg, rdata_next;
  logic        err_reg, err_next;

  logic             accept;
  logic             access_en;
  logic             acc_we;
  logic [31:0]      acc_addr, acc_wdata;
  logic [3:0]       acc_be;
  logic             acc_legal;
  logic [IDX_W-1:0] acc_idx;
  logic [3:0]       wr_mask;
  logic             wr_en;
  logic [31:0]      word_q [DEPTH];

  // Next state, wait counter and response registers.
  // A low rst takes priority over every other update.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    if (!rst) begin
      state_next = IDLE;
      cnt_next   = 4'd0;
      rdata_next = 32'd0;
      err_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (WAIT_CYCLES == 0) begin
              state_next = RESP;
            end else begin
              state_next = WAIT;
              cnt_next   = CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) state_next = RESP;
          else                 cnt_next   = cnt_reg - 4'd1;
        end
        RESP: begin
          if (rsp_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
      if (access_en) begin
        err_next   = !acc_legal;
        rdata_next = (acc_legal && !acc_we) ? word_q[acc_idx] : 32'd0;
      end
    end
  end

  // Select the access operands.
  // With zero wait cycles the access happens on the accept edge itself, so
  // the live request fields are used instead of the latched copies.
  always_comb begin
    accept    = req_valid && (state_reg == IDLE);
    acc_we    = (state_reg == IDLE) ? req_we    : we_reg;
    acc_addr  = (state_reg == IDLE) ? req_addr  : addr_reg;
    acc_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;
    acc_be    = (state_reg == IDLE) ? req_be    : be_reg;
    acc_legal = (acc_addr[1:0] == 2'b00) && (acc_addr[31:2] < 30'(DEPTH));
    acc_idx   = acc_addr[IDX_W+1:2];
    access_en = (state_next == RESP) && (state_reg != RESP);
    wr_en     = access_en && acc_we && acc_legal;
`ifdef DMEM_BYTE_STROBE_EN
    wr_mask   = acc_be;
`else
    wr_mask   = 4'hF;
`endif
  end

`ifndef DMEM_BYTE_STROBE_EN
  // Strobes are latched but deliberately ignored in the full-word build.
  logic unused_be;
  assign unused_be = ^acc_be;
`endif

  // FSM, counter and response registers.
  always_ff @(posedge clk) begin
    state_reg <= state_next;
    cnt_reg   <= cnt_next;
    rdata_reg <= rdata_next;
    err_reg   <= err_next;
  end

  // Capture the request on accept.
  // Later input changes cannot disturb the pending access.
  always_ff @(posedge clk) begin
    if (rst && accept) begin
      we_reg    <= req_we;
      addr_reg  <= req_addr;
      wdata_reg <= req_wdata;
      be_reg    <= req_be;
    end
  end

  // One register per word, preloaded with its own index and never touched by
  // rst. A store writes the enabled byte lanes.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [31:0] word_reg = 32'(gi);
      // Byte-lane write of this word.
      always_ff @(posedge clk) begin
        if (wr_en && (acc_idx == IDX_W'(gi))) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_mask[b]) word_reg[8*b +: 8] <= acc_wdata[8*b +: 8];
          end
        end
      end
      assign word_q[gi] = word_reg;
    end
  endgenerate

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign busy      = (state_reg != IDLE);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SHALL set the number of wait cycles between request accept and response; legal range 0..15.
REQ-002 Parameter DEPTH, default 128, SHALL set the number of 32-bit words in the memory array.
REQ-003 clk  input  1  SHALL be the clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous, active-low.
REQ-005 req_valid  input  1  SHALL indicate that the core presents a load or store request.
REQ-006 req_ready  output  1  SHALL indicate that the block can accept a request this cycle.
REQ-007 req_we  input  1  SHALL select the access type: 1 = store, 0 = load.
REQ-008 req_addr  input  32  SHALL carry the byte address.
REQ-009 req_wdata  input  32  SHALL carry the store data.
REQ-010 req_be  input  4  SHALL carry the byte-lane write strobes; it is used only when the configuration macro is defined.
REQ-011 rsp_valid  output  1  SHALL indicate that a response is presented.
REQ-012 rsp_ready  input  1  SHALL indicate that the core accepts the response.
REQ-013 rsp_rdata  output  32  SHALL carry the load data.
REQ-014 rsp_err  output  1  SHALL flag an illegal access.
REQ-015 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have three states (IDLE, WAIT, RESP), with req_ready = 1 only in IDLE.
REQ-017 A request SHALL be accepted on an edge where req_valid and req_ready are both high; the block latches we, addr, wdata and be at that edge.
REQ-018 On accept, the FSM SHALL go to WAIT with its counter loaded to WAIT_CYCLES-1, or go directly to RESP when WAIT_CYCLES = 0.
REQ-019 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go to RESP on the edge where the counter equals 0.
REQ-020 Latency: for an accept at edge k, rsp_valid SHALL first be high in the cycle after edge k+WAIT_CYCLES.
REQ-021 The access SHALL be performed on the edge entering RESP, using the word index addr[31:2].
REQ-022 An access is illegal when addr[1:0] != 0 or the word index is >= DEPTH; an illegal access SHALL give rsp_err = 1, rsp_rdata = 0 and no memory write.
REQ-023 A legal load SHALL give rsp_rdata = mem[index] and rsp_err = 0.
REQ-024 A legal store SHALL write mem[index], with rsp_rdata = 0 and rsp_err = 0.
REQ-025 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready is sampled high; at that edge the FSM SHALL go to IDLE.
REQ-026 If rsp_ready is already high when rsp_valid first rises, the response SHALL complete at the next edge, and req_ready SHALL rise in the following cycle.
REQ-027 There is no same-cycle accept-on-complete, so maximum throughput SHALL be one transaction per WAIT_CYCLES+2 cycles.
REQ-028 req_valid SHALL be ignored while req_ready = 0, and input changes after accept SHALL NOT affect the pending transaction.
REQ-029 The memory SHALL initialise to mem[i] = i at time zero and SHALL NOT be cleared by rst.

Reset
REQ-030 While rst = 0 at an edge, the state SHALL go to IDLE and the counter to 0.
REQ-031 Reset values: rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0, and req_ready = 1 from the next cycle.
REQ-032 A reset during WAIT SHALL discard the pending store uncommitted; a reset during RESP SHALL drop the response; memory contents SHALL be preserved in both cases.

Configuration
REQ-033 Macro DMEM_BYTE_STROBE_EN SHALL control byte-lane stores.
- Defined: a legal store SHALL update only lane i (bits 8i+7:8i) where req_be[i] = 1; req_be = 0000 SHALL complete with no change and rsp_err = 0.
- Undefined: req_be SHALL be ignored and every legal store SHALL write all 32 bits.

Verification
REQ-034 Reset, then load 0x20 (WAIT_CYCLES = 2) -> rsp_valid in the 3rd cycle after the accept edge, rsp_rdata = 8, rsp_err = 0, busy high throughout.
REQ-035 Store 0xDEADBEEF to 0x40, then load 0x40 -> rsp_rdata = 0xDEADBEEF; a load of 0x44 still returns 17.
REQ-036 Load 0x41 -> rsp_err = 1, rsp_rdata = 0; load 0x200 -> rsp_err = 1; store 0xFFFFFFFF to 0x202, then load 0x200 & ~3 -> unchanged.
REQ-037 Hold rsp_ready = 0 for 5 cycles with a second req_valid pulsed -> rsp_* stable, req_ready = 0, the second request not accepted; rsp_ready = 1 -> IDLE on the next edge.
REQ-038 Store 0x11111111 to 0x10 with rst pulsed low during WAIT -> rsp_valid = 0, state IDLE; a later load of 0x10 returns 4.
REQ-039 With DMEM_BYTE_STROBE_EN defined, store 0xAABBCCDD to 0x10 with be = 0010 -> a load of 0x10 returns 0x0000CC04; without the macro it returns 0xAABBCCDD.
